// File: rtl/tdm_demux.sv
// tdm_demux
// ---------
// Receive side of the 2:1 TDM mux path. The block samples the serial line
// `y` and the select `s` on every cycle with `en`=1. It routes each bit to
// the channel named by `s`. Each channel deserializes its bits LSB-first into
// a WIDTH-bit word and hands the word to a consumer over a valid/ack
// handshake. Overrun is flagged (sticky) when a new word lands on a word that
// has not been acknowledged.
//
// Optional feature: define TDM_DEMUX_PARITY_EN to expect one even-parity bit
// after each word. A word then has WIDTH+1 bits, and perr_c is a sticky flag
// for a failed parity check. Without the macro, perr0/perr1 are tied to 0.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   y            multiplexed serial data bit
//   s            channel select for y (0 -> channel 0, 1 -> channel 1)
//   en           sample strobe
//   ack0/ack1    consumer acknowledge per channel
//   o0/o1        recovered words (WIDTH bits)
//   v0/v1        word valid, held until acknowledged
//   ovr0/ovr1    sticky overrun flags
//   perr0/perr1  sticky parity-error flags
module tdm_demux #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             y,
    input  logic             s,
    input  logic             en,
    input  logic             ack0,
    input  logic             ack1,
    output logic [WIDTH-1:0] o0,
    output logic [WIDTH-1:0] o1,
    output logic             v0,
    output logic             v1,
    output logic             ovr0,
    output logic             ovr1,
    output logic             perr0,
    output logic             perr1
);

`ifdef TDM_DEMUX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    // Number of serial bits per word, including the parity bit when enabled.
    localparam int SRW = WIDTH + PAR;
    localparam int CW  = $clog2(SRW);
    localparam logic [CW-1:0] LAST_C = CW'(SRW - 1);

    logic [1:0]       w_ack;
    logic [WIDTH-1:0] w_o [2];
    logic [1:0]       w_v;
    logic [1:0]       w_ovr;
    logic [1:0]       w_perr;

    assign w_ack = {ack1, ack0};

    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic [SRW-1:0]   r_sr;
        logic [CW-1:0]    r_cnt;
        logic [WIDTH-1:0] r_o;
        logic             r_v;
        logic             r_ovr;
        logic             w_hit;
        logic             w_done;
        logic [SRW-1:0]   w_word;

        assign w_hit  = en && (s == 1'(c));
        assign w_done = w_hit && (r_cnt == LAST_C);
        // The newest bit enters at the top. After SRW shifts, bit 0 holds the
        // first bit received. So the completed word is already LSB-first.
        assign w_word = {y, r_sr[SRW-1:1]};

        always_ff @(posedge clk) begin
            if (rst) begin
                r_sr  <= '0;
                r_cnt <= '0;
                r_o   <= '0;
                r_v   <= 1'b0;
                r_ovr <= 1'b0;
            end else begin
                if (w_hit) begin
                    r_sr  <= w_word;
                    r_cnt <= w_done ? '0 : r_cnt + 1'b1;
                end
                if (w_done) begin
                    r_o <= w_word[WIDTH-1:0];
                    r_v <= 1'b1;
                    // A completion with a same-cycle ack counts as consumed, not as an overrun.
                    if (r_v && !w_ack[c])
                        r_ovr <= 1'b1;
                end else if (r_v && w_ack[c]) begin
                    r_v <= 1'b0;
                end
            end
        end

`ifdef TDM_DEMUX_PARITY_EN
        logic r_perr;
        always_ff @(posedge clk) begin
            if (rst)
                r_perr <= 1'b0;
            else if (w_done && (^w_word))
                r_perr <= 1'b1;
        end
        assign w_perr[c] = r_perr;
`else
        assign w_perr[c] = 1'b0;
`endif

        assign w_o[c]   = r_o;
        assign w_v[c]   = r_v;
        assign w_ovr[c] = r_ovr;
    end

    assign o0    = w_o[0];
    assign o1    = w_o[1];
    assign v0    = w_v[0];
    assign v1    = w_v[1];
    assign ovr0  = w_ovr[0];
    assign ovr1  = w_ovr[1];
    assign perr0 = w_perr[0];
    assign perr1 = w_perr[1];

endmodule

// File: tb/tb_tdm_demux.sv
module tb_tdm_demux;
    localparam int W = 8;
`ifdef TDM_DEMUX_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic clk = 1'b0;
    logic rst, y, s, en, ack0, ack1;
    logic [W-1:0] o0, o1;
    logic v0, v1, ovr0, ovr1, perr0, perr1;

    int tot = 0;
    int bad = 0;

    tdm_demux #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .y(y), .s(s), .en(en),
        .ack0(ack0), .ack1(ack1),
        .o0(o0), .o1(o1), .v0(v0), .v1(v1),
        .ovr0(ovr0), .ovr1(ovr1), .perr0(perr0), .perr1(perr1)
    );

    always #5 clk = ~clk;

    // Reference model. Bits are collected per channel in a queue. When the
    // queue holds a full word, the word is rebuilt arithmetically.
    bit          q0[$];
    bit          q1[$];
    int unsigned m_o[2];
    bit          m_v[2];
    bit          m_ovr[2];
    bit          m_perr[2];

    task automatic model_deliver(input int ch, input int unsigned word, input bit perr, input bit ack);
        if (m_v[ch] && !ack) m_ovr[ch] = 1'b1;
        m_o[ch] = word;
        m_v[ch] = 1'b1;
        if (perr) m_perr[ch] = 1'b1;
    endtask

    task automatic step(input bit ry, input bit rs, input bit ren,
                        input bit ra0, input bit ra1, input bit rrst);
        int unsigned word;
        bit par;
        bit done0, done1;
        y = ry; s = rs; en = ren; ack0 = ra0; ack1 = ra1; rst = rrst;
        @(posedge clk);
        done0 = 1'b0; done1 = 1'b0;
        if (rrst) begin
            q0.delete(); q1.delete();
            for (int c = 0; c < 2; c++) begin
                m_o[c] = 0; m_v[c] = 0; m_ovr[c] = 0; m_perr[c] = 0;
            end
        end else begin
            if (ren) begin
                if (rs) q1.push_back(ry); else q0.push_back(ry);
            end
            if (q0.size() == NB) begin
                word = 0; par = 1'b0;
                for (int k = 0; k < NB; k++) begin
                    if (k < W) word = word + (int'(q0[k]) << k);
                    par = par ^ q0[k];
                end
                q0.delete();
                model_deliver(0, word, par & (NB != W), ra0);
                done0 = 1'b1;
            end
            if (q1.size() == NB) begin
                word = 0; par = 1'b0;
                for (int k = 0; k < NB; k++) begin
                    if (k < W) word = word + (int'(q1[k]) << k);
                    par = par ^ q1[k];
                end
                q1.delete();
                model_deliver(1, word, par & (NB != W), ra1);
                done1 = 1'b1;
            end
            if (!done0 && m_v[0] && ra0) m_v[0] = 1'b0;
            if (!done1 && m_v[1] && ra1) m_v[1] = 1'b0;
        end
        #1;
    endtask

    // Sends one word on channel ch. When parity is enabled, an even-parity
    // bit follows the data; flip=1 corrupts it. ack_last sets the ack on
    // the completing bit.
    task automatic send_word(input int ch, input logic [31:0] data, input bit flip, input bit ack_last);
        bit b;
        bit a;
        logic [W-1:0] d;
        d = data[W-1:0];
        for (int k = 0; k < NB; k++) begin
            b = (k < W) ? d[k] : ((^d) ^ flip);
            a = ack_last && (k == NB - 1);
            step(b, ch[0], 1'b1, a && ch == 0, a && ch == 1, 1'b0);
        end
    endtask

    task automatic test_reset();
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        tot++; if ({o0, o1} !== '0) begin bad++; $display("FAIL reset_o o0=%h o1=%h exp 0 0", o0, o1); end
        tot++; if ({v0, v1} !== 2'b00) begin bad++; $display("FAIL reset_v v=%b%b exp 00", v1, v0); end
        tot++; if ({ovr0, ovr1, perr0, perr1} !== 4'b0) begin bad++; $display("FAIL reset_flags got %b%b%b%b exp 0000", ovr0, ovr1, perr0, perr1); end
    endtask

    task automatic test_single();
        logic [W-1:0] d = 8'hA5;
        bit b;
        for (int k = 0; k < NB; k++) begin
            tot++; if (v0 !== 1'b0) begin bad++; $display("FAIL single_early_v0 bit=%0d got=%b exp=0", k, v0); end
            b = (k < W) ? d[k] : ^d;
            step(b, 0, 1, 0, 0, 0);
        end
        tot++; if (o0 !== 8'hA5 || v0 !== 1'b1) begin bad++; $display("FAIL single_word o0=%h v0=%b exp a5 1", o0, v0); end
        tot++; if (v1 !== 1'b0 || o1 !== 8'h00) begin bad++; $display("FAIL single_ch1 o1=%h v1=%b exp 00 0", o1, v1); end
        step(0, 0, 0, 1, 0, 0);
        tot++; if (v0 !== 1'b0) begin bad++; $display("FAIL single_ack v0=%b exp 0", v0); end
    endtask

    task automatic test_interleave();
        logic [W-1:0] d0 = 8'h3C;
        logic [W-1:0] d1 = 8'hC3;
        bit b;
        for (int k = 0; k < NB; k++) begin
            b = (k < W) ? d0[k] : ^d0;
            step(b, 0, 1, 0, 0, 0);
            if (k == NB - 1) begin
                tot++; if (v0 !== 1'b1 || v1 !== 1'b0) begin bad++; $display("FAIL ilv_order v0=%b v1=%b exp 1 0", v0, v1); end
            end
            b = (k < W) ? d1[k] : ^d1;
            step(b, 1, 1, 0, 0, 0);
        end
        tot++; if (o0 !== 8'h3C || o1 !== 8'hC3) begin bad++; $display("FAIL ilv_words o0=%h o1=%h exp 3c c3", o0, o1); end
        tot++; if (v1 !== 1'b1 || ovr0 !== 1'b0 || ovr1 !== 1'b0) begin bad++; $display("FAIL ilv_flags v1=%b ovr=%b%b exp 1 00", v1, ovr1, ovr0); end
        step(0, 0, 0, 1, 1, 0);
    endtask

    task automatic test_gaps();
        logic [W-1:0] d = 8'h5A;
        bit b;
        for (int k = 0; k < NB; k++) begin
            b = (k < W) ? d[k] : ^d;
            step(b, 1, 1, 0, 0, 0);
            step(~b, 1, 0, 0, 0, 0);
            if (k == NB - 2) begin
                tot++; if (v1 !== 1'b0) begin bad++; $display("FAIL gaps_early v1=%b exp 0", v1); end
            end
        end
        tot++; if (o1 !== 8'h5A || v1 !== 1'b1) begin bad++; $display("FAIL gaps_word o1=%h v1=%b exp 5a 1", o1, v1); end
        step(0, 0, 0, 0, 1, 0);
    endtask

    task automatic test_overrun();
        logic [W-1:0] d = 8'h44;
        bit b;
        send_word(0, 32'h11, 0, 0);
        send_word(0, 32'h22, 0, 0);
        tot++; if (o0 !== 8'h22 || v0 !== 1'b1 || ovr0 !== 1'b1 || ovr1 !== 1'b0) begin
            bad++; $display("FAIL ovr_set o0=%h v0=%b ovr0=%b ovr1=%b exp 22 1 1 0", o0, v0, ovr0, ovr1); end
        step(0, 0, 0, 1, 0, 0);
        tot++; if (v0 !== 1'b0 || ovr0 !== 1'b1) begin bad++; $display("FAIL ovr_ack v0=%b ovr0=%b exp 0 1", v0, ovr0); end
        send_word(0, 32'h33, 0, 0);
        for (int k = 0; k < NB; k++) begin
            b = (k < W) ? d[k] : ^d;
            step(b, 0, 1, k == NB - 1, 0, 0);
            tot++; if (v0 !== 1'b1) begin bad++; $display("FAIL ovr_cont_v0 bit=%0d got=%b exp=1", k, v0); end
        end
        tot++; if (o0 !== 8'h44 || ovr0 !== 1'b1) begin bad++; $display("FAIL ovr_same o0=%h ovr0=%b exp 44 1", o0, ovr0); end
        send_word(1, 32'h55, 0, 0);
        send_word(1, 32'h66, 0, 1);
        tot++; if (o1 !== 8'h66 || v1 !== 1'b1 || ovr1 !== 1'b0) begin
            bad++; $display("FAIL ovr_same1 o1=%h v1=%b ovr1=%b exp 66 1 0", o1, v1, ovr1); end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] d = 8'h81;
        bit b;
        for (int k = 0; k < 4; k++) step(1, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        for (int k = 0; k < NB; k++) begin
            tot++; if (v0 !== 1'b0 || o0 !== 8'h00) begin bad++; $display("FAIL rmid_early bit=%0d v0=%b o0=%h exp 0 00", k, v0, o0); end
            b = (k < W) ? d[k] : ^d;
            step(b, 0, 1, 0, 0, 0);
        end
        tot++; if (o0 !== 8'h81 || v0 !== 1'b1) begin bad++; $display("FAIL rmid_word o0=%h v0=%b exp 81 1", o0, v0); end
        step(0, 0, 0, 1, 0, 0);
    endtask

`ifdef TDM_DEMUX_PARITY_EN
    task automatic test_parity();
        send_word(0, 32'h07, 0, 0);
        tot++; if (perr0 !== 1'b0 || o0 !== 8'h07) begin bad++; $display("FAIL par_good perr0=%b o0=%h exp 0 07", perr0, o0); end
        step(0, 0, 0, 1, 0, 0);
        send_word(0, 32'h07, 1, 0);
        tot++; if (perr0 !== 1'b1 || o0 !== 8'h07 || v0 !== 1'b1 || perr1 !== 1'b0) begin
            bad++; $display("FAIL par_bad perr0=%b o0=%h v0=%b perr1=%b exp 1 07 1 0", perr0, o0, v0, perr1); end
    endtask
`endif

    task automatic test_random();
        step(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 199) == 0);
            tot++;
            if (o0 !== m_o[0][W-1:0] || o1 !== m_o[1][W-1:0] || v0 !== m_v[0] || v1 !== m_v[1] ||
                ovr0 !== m_ovr[0] || ovr1 !== m_ovr[1] || perr0 !== m_perr[0] || perr1 !== m_perr[1]) begin
                bad++;
                $display("FAIL random cyc=%0d got o=%h/%h v=%b%b ovr=%b%b perr=%b%b exp o=%h/%h v=%b%b ovr=%b%b perr=%b%b",
                         i, o0, o1, v0, v1, ovr0, ovr1, perr0, perr1,
                         m_o[0][W-1:0], m_o[1][W-1:0], m_v[0], m_v[1], m_ovr[0], m_ovr[1], m_perr[0], m_perr[1]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; y = 1'b0; s = 1'b0; en = 1'b0; ack0 = 1'b0; ack1 = 1'b0;
        test_reset();
        test_single();
        test_interleave();
        test_gaps();
        test_overrun();
        test_reset_mid();
`ifdef TDM_DEMUX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end
endmodule
